// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC owner, in-order imem requests, instruction FIFO
//
// Purpose: issues in-order 16-bit word fetches to a variable-latency instruction
// memory, buffers responses in a DEPTH-entry FIFO tagged with their PC and hands
// them to decode. Redirects flush and refetch; HLT freezes issue until reset.
//
// Optional feature macro: FETCH_BYPASS_EN (response forwarded straight to decode
// when the FIFO is empty; default build has no bypass and one cycle of latency).
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   redirect_valid, redirect_pc   taken branch/jump: flush and refetch from target
//   halt / halted                 freeze issue (sticky) / issue frozen
//   imem_req, imem_addr, imem_ready   request channel to instruction memory
//   imem_rvalid, imem_rdata       in-order response channel
//   if_valid, if_instr, if_pc, if_pcs, id_ready   instruction handoff to decode
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          DEPTH    = 4,
    parameter int          OUTST    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    output logic        if_valid,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    output logic [15:0] if_pcs,
    input  logic        id_ready,
    output logic        halted
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0]   DEPTH_L = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] OUTST_L = CW'(OUTST);

    logic [15:0]   fetch_pc_q, fetch_pc_d;
    logic [15:0]   resp_pc_q, resp_pc_d;
    logic [15:0]   fifo_instr_q [DEPTH];
    logic [15:0]   fifo_pc_q    [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    // outst counts every in-flight request, including those already marked for discard
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] discard_q, discard_d;
    logic          halted_q, halted_d;

    logic          fifo_empty;
    logic [CW:0]   occupancy;
    logic          can_issue;
    logic          issue;
    logic          drop;
    logic          accept;
    logic          byp;
    logic          push;
    logic          pop;

    always_comb begin
        fifo_empty = (count_q == '0);
        // A FIFO slot is reserved at issue, so every response is guaranteed room
        occupancy  = {1'b0, count_q} + {1'b0, outst_q};
        can_issue  = (outst_q < OUTST_L) && (occupancy < DEPTH_L);
        imem_req   = !rst && !halted_q && !halt && !redirect_valid && can_issue;
        imem_addr  = fetch_pc_q;
        issue      = imem_req && imem_ready;

        drop       = imem_rvalid && (discard_q != '0);
        accept     = imem_rvalid && !drop;

`ifdef FETCH_BYPASS_EN
        byp        = accept && fifo_empty && !redirect_valid && !rst;
`else
        byp        = 1'b0;
`endif

        if_valid   = !rst && !redirect_valid && (!fifo_empty || byp);
        if_instr   = byp ? imem_rdata : fifo_instr_q[rd_ptr_q];
        if_pc      = byp ? resp_pc_q  : fifo_pc_q[rd_ptr_q];
        if_pcs     = if_pc + 16'd2;
        halted     = halted_q || (halt && !rst);

        // A bypassed word consumed by decode never enters the FIFO
        pop        = if_valid && id_ready && !byp;
        push       = accept && !redirect_valid && !(byp && id_ready);

        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        discard_d  = discard_q;
        halted_d   = halted_q || halt;
        outst_d    = outst_q + CW'(issue) - CW'(imem_rvalid);

        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[15:1], 1'b0};
            resp_pc_d  = {redirect_pc[15:1], 1'b0};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            // Everything still in flight after this cycle belongs to the old stream
            discard_d  = outst_q - CW'(imem_rvalid);
        end else begin
            if (issue)  fetch_pc_d = fetch_pc_q + 16'd2;
            if (accept) resp_pc_d  = resp_pc_q + 16'd2;
            if (drop)   discard_d  = discard_q - CW'(1);
            if (push)   wr_ptr_d   = wr_ptr_q + AW'(1);
            if (pop)    rd_ptr_d   = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
            halted_q   <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            halted_q   <= halted_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by count_q
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr_q[wr_ptr_q] <= imem_rdata;
            fifo_pc_q[wr_ptr_q]    <= resp_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with random memory latency
module tb_fetch_unit;

    localparam logic [15:0] RST_PC = 16'hFFFC;
    localparam int          DEPTH  = 4;
    localparam int          OUTST  = 2;
`ifdef FETCH_BYPASS_EN
    localparam logic        BYP    = 1'b1;
`else
    localparam logic        BYP    = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [15:0] if_pcs;
    logic        id_ready;
    logic        halted;

    fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH), .OUTST(OUTST)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt(halt),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pcs(if_pcs),
        .id_ready(id_ready), .halted(halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct { logic [15:0] pc; logic [15:0] instr; } exp_t;
    typedef struct { logic [15:0] addr; int due; } mreq_t;

    exp_t        sbq[$];
    mreq_t       memq[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_due = 0;
    logic [15:0] exp_fetch_pc = RST_PC;
    bit          halted_m = 0;
    bit          stream_chk = 0;

    // stimulus knobs, applied by step() at the next falling edge
    bit          rst_m = 1;
    bit          halt_pulse = 0;
    bit          redir_pulse = 0;
    logic [15:0] redir_target = 16'h0;
    int          ready_pct = 100;
    int          id_pct = 100;
    int          redir_pct = 0;
    int          lat_min = 1;
    int          lat_max = 1;

    function automatic logic [15:0] mword(input logic [15:0] a);
        return {a[7:0] ^ 8'hA5, a[15:8] + 8'h3C} ^ 16'h1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        int    lat;
        mreq_t m;
        @(negedge clk);
        cyc++;
        rst            = rst_m;
        halt           = halt_pulse;
        halt_pulse     = 0;
        redirect_valid = redir_pulse || (!rst_m && ($urandom_range(0, 99) < redir_pct));
        redirect_pc    = redir_pulse ? redir_target : 16'($urandom);
        redir_pulse    = 0;
        imem_ready     = ($urandom_range(0, 99) < ready_pct);
        id_ready       = ($urandom_range(0, 99) < id_pct);
        if (!rst && memq.size() > 0 && memq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mword(memq[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 16'($urandom);
        end
        #1;
        if (rst) begin
            chk("rst_imem_req", imem_req, 0);
            chk("rst_if_valid", if_valid, 0);
            sbq.delete();
            memq.delete();
            exp_fetch_pc = RST_PC;
            halted_m = 0;
            last_due = cyc;
        end else begin
            if (redirect_valid || halted_m || halt)
                chk("req_blocked", imem_req, 0);
            if (memq.size() >= OUTST)
                chk("req_outst_limit", imem_req, 0);
            if (imem_req)
                chk("imem_addr", imem_addr, exp_fetch_pc);
            if (redirect_valid)
                chk("valid_in_redirect", if_valid, 0);
            chk("halted", halted, halted_m || halt);
            if (imem_rvalid)
                void'(memq.pop_front());
            if (redirect_valid) begin
                sbq.delete();
                exp_fetch_pc = {redirect_pc[15:1], 1'b0};
            end else if (imem_req && imem_ready) begin
                lat = $urandom_range(lat_min, lat_max);
                m.addr = imem_addr;
                m.due  = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
                last_due = m.due;
                memq.push_back(m);
                sbq.push_back('{pc: imem_addr, instr: mword(imem_addr)});
                exp_fetch_pc = exp_fetch_pc + 16'd2;
            end
            if (halt) halted_m = 1;
        end
    endtask

    // monitor: compares whatever decode consumes against the scoreboard head
    initial begin
        exp_t        e;
        logic [15:0] pcs;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (stream_chk) chk("no_gap", if_valid, 1);
                if (if_valid) begin
                    chk("valid_has_expect", sbq.size() != 0, 1);
                    if (id_ready && sbq.size() != 0) begin
                        e   = sbq.pop_front();
                        pcs = e.pc + 16'd2;
                        chk("if_pc", if_pc, e.pc);
                        chk("if_instr", if_instr, e.instr);
                        chk("if_pcs", if_pcs, pcs);
                    end
                end
            end
        end
    end

    task automatic drain(input string name);
        int n;
        ready_pct = 0; redir_pct = 0; id_pct = 100;
        n = 0;
        while ((memq.size() != 0 || sbq.size() != 0) && n < 80) begin
            step();
            n++;
        end
        chk(name, (memq.size() == 0) && (sbq.size() == 0), 1);
    endtask

    initial begin
        int n;
        rst = 1; halt = 0; redirect_valid = 0; redirect_pc = 0;
        imem_ready = 0; imem_rvalid = 0; imem_rdata = 0; id_ready = 0;

        // reset, then 1-cycle memory streaming (addresses wrap FFFC,FFFE,0000)
        rst_m = 1;
        repeat (3) step();
        rst_m = 0;
        ready_pct = 100; id_pct = 100; lat_min = 1; lat_max = 1;
        step();
        chk("post_rst_if_valid", if_valid, 0);
        repeat (4) step();
        stream_chk = 1;
        repeat (16) step();
        stream_chk = 0;

        // decode stalls: FIFO fills to DEPTH, issue stops
        id_pct = 0;
        repeat (10) step();
        chk("full_entries", sbq.size(), DEPTH);
        chk("full_no_req", imem_req, 0);
        id_pct = 100;
        repeat (8) step();

        // latency 3, redirect to odd target with requests in flight
        lat_min = 3; lat_max = 3;
        n = 0;
        while (memq.size() < 2 && n < 20) begin step(); n++; end
        chk("two_in_flight", memq.size(), 2);
        redir_pulse = 1; redir_target = 16'h0041;
        step();
        n = 0;
        do begin step(); n++; end while (!imem_req && n < 10);
        chk("redir_first_addr", imem_addr, 16'h0040);
        repeat (10) step();

        // randomized traffic with occasional redirects
        ready_pct = 70; id_pct = 60; redir_pct = 3; lat_min = 1; lat_max = 4;
        repeat (600) step();

        // single response into an empty FIFO: bypass vs registered latency
        drain("drain_before_byp");
        lat_min = 2; lat_max = 2; ready_pct = 100;
        step();
        ready_pct = 0;
        n = 0;
        do begin step(); n++; end while (!imem_rvalid && n < 10);
        chk("resp_seen", imem_rvalid, 1);
        chk("byp_same_cycle", if_valid, BYP);
        step();
        chk("byp_next_cycle", if_valid, !BYP);
        drain("drain_after_byp");

        // halt with requests in flight: they drain, then nothing more
        ready_pct = 100; id_pct = 100; lat_min = 3; lat_max = 3;
        repeat (6) step();
        halt_pulse = 1;
        step();
        chk("halt_in_flight", memq.size() != 0 || sbq.size() != 0, 1);
        repeat (15) step();
        chk("halt_drained", sbq.size() + memq.size(), 0);
        chk("halt_if_valid", if_valid, 0);
        redir_pulse = 1; redir_target = 16'h1230;
        repeat (6) step();
        chk("halt_after_redir", halted, 1);

        // reset mid-stream
        rst_m = 1;
        step();
        rst_m = 0;
        ready_pct = 100; id_pct = 70; lat_min = 2; lat_max = 2;
        repeat (8) step();
        rst_m = 1;
        step();
        rst_m = 0;
        step();
        chk("rst2_if_valid", if_valid, 0);
        chk("rst2_halted", halted, 0);
        ready_pct = 80; id_pct = 50; lat_min = 1; lat_max = 4;
        repeat (100) step();
        drain("final_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
